// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - execute/fetch-side signal bundle for the PC redirect controller
// Purpose: groups the branch decision, fetch status and PC/flush results into one port.
// Signals:
//   stall, imem_busy                      pipeline hazard stall and outstanding fetch access
//   branch_valid, branch_type, jump,
//   b_taken, branch_target                execute-stage control-flow decision
//   pc, flush, misalign_err, redirect_cnt controller results
// Modports: master drives decisions and status; slave is the controller.
interface pc_redirect_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic             branch_valid;
  logic [2:0]       branch_type;
  logic             jump;
  logic             b_taken;
  logic [XLEN-1:0]  branch_target;
  logic             imem_busy;
  logic [XLEN-1:0]  pc;
  logic             flush;
  logic             misalign_err;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall, branch_valid, branch_type, jump, b_taken, branch_target, imem_busy,
    input  pc, flush, misalign_err, redirect_cnt
  );

  modport slave (
    input  stall, branch_valid, branch_type, jump, b_taken, branch_target, imem_busy,
    output pc, flush, misalign_err, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC register with branch redirect, deferred load and IF/ID flush
// Purpose: owns the fetch PC, advances it by 4, applies taken branches/jumps as redirects,
//   and holds a redirect aside while instruction memory has an access in flight.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of pc_redirect_ctrl_if (decision inputs; pc, flush, misalign_err,
//        redirect_cnt outputs)
module pc_redirect_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  pc_redirect_ctrl_if.slave bus
);
  localparam logic [2:0] BT_NONE = 3'd0;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             take, aligned;
  logic             cnt_inc, flush_c, mis_c;

  assign take    = bus.branch_valid & (bus.jump | ((bus.branch_type != BT_NONE) & bus.b_taken));
  assign aligned = (bus.branch_target[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_inc = 1'b0;
    flush_c = 1'b0;
    mis_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (take && aligned) begin
          // Redirect wins over stall; a busy fetch only delays the PC load.
          flush_c = 1'b1;
          cnt_inc = 1'b1;
          if (bus.imem_busy) begin
            pend_d  = bus.branch_target;
            state_d = ST_HOLD;
          end else begin
            pc_d = bus.branch_target;
          end
        end else begin
          // A misaligned taken target is reported and otherwise treated as fall-through.
          mis_c = take;
          if (!bus.stall && !bus.imem_busy) begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      ST_HOLD: begin
        // Everything returning from the in-flight access is wrong-path; execute is also
        // being flushed, so branch_valid and stall are ignored here.
        flush_c = 1'b1;
        if (!bus.imem_busy) begin
          pc_d    = pend_q;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Combinational outputs are forced low while reset is held so inputs cannot leak through.
  assign bus.pc           = pc_q;
  assign bus.flush        = flush_c & ~rst;
  assign bus.misalign_err = mis_c & ~rst;
  assign bus.redirect_cnt = cnt_q;
endmodule
